// File: rtl/alu32.sv
// alu32: 32-bit registered integer ALU.
// Operations: AND, OR, ADD, SUB, SLT. Codes 011/100/101 produce zero.
// Outputs sum, zout and status are registered, so results appear one cycle after the inputs.
// Optional feature: define ALU32_STATUS_EN to build the N/Z/V status register.
// When that macro is undefined, status is a constant 3'b000.

module alu32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  gin,
    output logic [31:0] sum,
    output logic        zout,
    output logic [2:0]  status
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic        v_sub;
    logic [31:0] sum_d;
    logic [31:0] sum_q;
    logic        zout_d;
    logic        zout_q;

    // Shared adder paths. The subtract overflow bit also corrects the SLT compare.
    always_comb begin
        add_res = a + b;
        sub_res = a + ~b + 32'd1;
        v_sub   = (a[31] != b[31]) && (sub_res[31] != a[31]);
    end

    // Result select. Unused codes fall through and produce zero.
    always_comb begin
        sum_d = '0;
        case (gin)
            OP_AND: sum_d = a & b;
            OP_OR:  sum_d = a | b;
            OP_ADD: sum_d = add_res;
            OP_SUB: sum_d = sub_res;
            OP_SLT: sum_d = {31'd0, sub_res[31] ^ v_sub};
            default: sum_d = '0;
        endcase
        zout_d = (sum_d == '0);
    end

    // Output register. Reset forces outputs low, including zout, even though the sum is zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            zout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            zout_q <= zout_d;
        end
    end

    assign sum  = sum_q;
    assign zout = zout_q;

`ifdef ALU32_STATUS_EN
    logic       v_d;
    logic [2:0] status_d;
    logic [2:0] status_q;

    // Overflow is reported only for ADD and SUB.
    always_comb begin
        v_d = 1'b0;
        case (gin)
            OP_ADD: v_d = (a[31] == b[31]) && (add_res[31] != a[31]);
            OP_SUB: v_d = v_sub;
            default: v_d = 1'b0;
        endcase
        status_d = {sum_d[31], zout_d, v_d};
    end

    // Status register {N, Z, V}. Its timing matches the sum and zout outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;
`else
    assign status = '0;
`endif

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed self-checking bench for alu32.
// A signed-arithmetic reference model is checked on every falling edge.
// Hand-computed literal expectations are checked after each rising edge.
// The bench honours ALU32_STATUS_EN in the same way as the design.

`timescale 1ns/1ps

module tb_alu32;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  gin;
    logic [31:0] sum;
    logic        zout;
    logic [2:0]  status;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_sum;
    logic        m_z;
    logic [2:0]  m_st;
    logic        m_valid = 1'b0;

    alu32 dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .gin    (gin),
        .sum    (sum),
        .zout   (zout),
        .status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model built from signed integer arithmetic rather than bit-level logic.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] g,
                                  output logic [31:0] r, output logic [2:0] st);
        longint sx;
        longint sy;
        longint t;
        logic   v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v  = 1'b0;
        r  = 32'd0;
        case (g)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin
                t = sx + sy;
                r = t[31:0];
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'b110: begin
                t = sx - sy;
                r = t[31:0];
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
`ifdef ALU32_STATUS_EN
        st = {r[31], (r == 32'd0), v};
`else
        st = 3'b000;
`endif
    endfunction

    // The model samples the same inputs that the DUT samples at each rising edge.
    always @(posedge clk) begin
        logic [31:0] r;
        logic [2:0]  st;
        if (reset) begin
            m_sum = 32'd0;
            m_z   = 1'b0;
            m_st  = 3'b000;
        end else begin
            model(a, b, gin, r, st);
            m_sum = r;
            m_z   = (r == 32'd0);
            m_st  = st;
        end
        m_valid = 1'b1;
    end

    // Continuous comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_sum", sum, m_sum);
            chk("model_zout", {31'd0, zout}, {31'd0, m_z});
            chk("model_status", {29'd0, status}, {29'd0, m_st});
        end
    end

    function automatic logic [2:0] st_exp(input logic [2:0] s);
`ifdef ALU32_STATUS_EN
        return s;
`else
        return 3'b000;
`endif
    endfunction

    // Drive one operation, wait for the capturing edge, then check the hand-computed result.
    task automatic step(input string name, input logic rst, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [2:0] g, input logic [31:0] es, input logic ez, input logic [2:0] est);
        reset = rst;
        a     = xa;
        b     = xb;
        gin   = g;
        @(posedge clk);
        #1;
        chk({name, "_sum"}, sum, es);
        chk({name, "_zout"}, {31'd0, zout}, {31'd0, ez});
        chk({name, "_status"}, {29'd0, status}, {29'd0, st_exp(est)});
    endtask

    initial begin
        reset = 1'b1;
        a     = 32'd1;
        b     = 32'd2;
        gin   = 3'b010;
        #1;
        // Hold reset for two edges while a live ADD is present on the inputs.
        step("rst0", 1'b1, 32'd1, 32'd2, 3'b010, 32'd0, 1'b0, 3'b000);
        step("rst1", 1'b1, 32'd1, 32'd2, 3'b010, 32'd0, 1'b0, 3'b000);
        step("add_first", 1'b0, 32'd1, 32'd2, 3'b010, 32'h00000003, 1'b0, 3'b000);
        // Back-to-back operations: each result must appear exactly one edge later.
        step("sub", 1'b0, 32'd3, 32'd2, 3'b110, 32'h00000001, 1'b0, 3'b000);
        step("slt_lt", 1'b0, 32'd1, 32'd2, 3'b111, 32'd1, 1'b0, 3'b000);
        step("slt_ovf", 1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1, 1'b0, 3'b000);
        step("slt_ge", 1'b0, 32'd2, 32'd1, 3'b111, 32'd0, 1'b1, 3'b010);
        step("and", 1'b0, 32'hFFFFFFFF, 32'h0000000F, 3'b000, 32'h0000000F, 1'b0, 3'b000);
        step("or", 1'b0, 32'hFFFFFFFF, 32'h00000000, 3'b001, 32'hFFFFFFFF, 1'b0, 3'b100);
        step("add_zero", 1'b0, 32'd0, 32'd0, 3'b010, 32'd0, 1'b1, 3'b010);
        step("add_wrap", 1'b0, 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b1, 3'b010);
        step("add_ovf", 1'b0, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 3'b101);
        step("sub_ovf", 1'b0, 32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 3'b001);
        step("sub_neg", 1'b0, 32'd0, 32'd1, 3'b110, 32'hFFFFFFFF, 1'b0, 3'b100);
        step("slt_neg", 1'b0, 32'hFFFFFFFE, 32'd3, 3'b111, 32'd1, 1'b0, 3'b000);
        step("unused101", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 32'd0, 1'b1, 3'b010);
        step("unused011", 1'b0, 32'h12345678, 32'h1, 3'b011, 32'd0, 1'b1, 3'b010);
        step("unused100", 1'b0, 32'h80000000, 32'h80000000, 3'b100, 32'd0, 1'b1, 3'b010);
        step("or_pre", 1'b0, 32'hA5A50000, 32'h00005A5A, 3'b001, 32'hA5A55A5A, 1'b0, 3'b100);
        // A reset asserted mid-stream must clear the outputs at that edge.
        step("rst_mid", 1'b1, 32'h7FFFFFFF, 32'd1, 3'b010, 32'd0, 1'b0, 3'b000);
        step("after_rst", 1'b0, 32'd5, 32'd7, 3'b010, 32'h0000000C, 1'b0, 3'b000);
        // Input changes between edges must not disturb the registered outputs.
        a   = 32'hDEADBEEF;
        gin = 3'b000;
        #3;
        chk("hold_sum", sum, 32'h0000000C);
        chk("hold_zout", {31'd0, zout}, 32'd0);
        step("and_hold", 1'b0, 32'hDEADBEEF, 32'h0000FFFF, 3'b000, 32'h0000BEEF, 1'b0, 3'b000);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
